// File: rtl/ldm_sequencer_if.sv
// Bundle of the ldm_sequencer request, memory-read, register-file and status signals.
// The sequencer sits on the master side; the core or bench drives the slave side.
interface ldm_sequencer_if;
  logic        START;
  logic [15:0] REG_LIST;
  logic [31:0] BASE;
  logic        INC;
  logic        WB_EN;
  logic [3:0]  BASE_REG;

  logic        MEM_RE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_RDATA;

  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;

  logic        PC_LOAD;
  logic [31:0] PC_DATA;
  logic        BUSY;
  logic        DONE;

  modport master (
    input  START, REG_LIST, BASE, INC, WB_EN, BASE_REG, MEM_RDATA,
    output MEM_RE, MEM_ADDR, WE3, A3, WD3, PC_LOAD, PC_DATA, BUSY, DONE
  );

  modport slave (
    output START, REG_LIST, BASE, INC, WB_EN, BASE_REG, MEM_RDATA,
    input  MEM_RE, MEM_ADDR, WE3, A3, WD3, PC_LOAD, PC_DATA, BUSY, DONE
  );
endinterface

// File: rtl/ldm_sequencer.sv
// Load-multiple sequencer: reads one word per listed register, lowest index first,
// writes it to the register file (or R15 via PC_LOAD), then optionally writes back the base.
module ldm_sequencer (
  input  logic                 CLK,
  input  logic                 RESET_N,
  ldm_sequencer_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    WBASE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] list_reg, list_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] final_base_reg, final_base_next;
  logic [3:0]  base_idx_reg, base_idx_next;
  logic        wb_pending_reg, wb_pending_next;

  logic [4:0]  start_cnt;
  logic [31:0] start_span;
  logic [3:0]  target;
  logic [15:0] list_remaining;

  logic        mem_re;
  logic [31:0] mem_addr;
  logic        we3;
  logic [3:0]  a3;
  logic [31:0] wd3;
  logic        pc_load;
  logic [31:0] pc_data;
  logic        done;

  // Transfer span 4*N, taken from the incoming list so the start address is ready on accept
  always_comb begin
    start_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      start_cnt = start_cnt + {4'd0, bus.REG_LIST[i]};
    end
    start_span = {25'd0, start_cnt, 2'b00};
  end

  // Lowest set bit of the remaining list picks the next register
  always_comb begin
    target = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_reg[i]) begin
        target = 4'(i);
      end
    end
    list_remaining = list_reg & ~(16'h0001 << target);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      list_reg       <= 16'd0;
      addr_reg       <= 32'd0;
      final_base_reg <= 32'd0;
      base_idx_reg   <= 4'd0;
      wb_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      list_reg       <= list_next;
      addr_reg       <= addr_next;
      final_base_reg <= final_base_next;
      base_idx_reg   <= base_idx_next;
      wb_pending_reg <= wb_pending_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    list_next       = list_reg;
    addr_next       = addr_reg;
    final_base_next = final_base_reg;
    base_idx_next   = base_idx_reg;
    wb_pending_next = wb_pending_reg;
    mem_re          = 1'b0;
    mem_addr        = 32'd0;
    we3             = 1'b0;
    a3              = 4'd0;
    wd3             = 32'd0;
    pc_load         = 1'b0;
    pc_data         = 32'd0;
    done            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.START) begin
          list_next       = bus.REG_LIST;
          addr_next       = bus.INC ? bus.BASE : (bus.BASE - start_span);
          final_base_next = bus.INC ? (bus.BASE + start_span) : (bus.BASE - start_span);
          base_idx_next   = bus.BASE_REG;
          // A base register that is also loaded keeps the loaded value
          wb_pending_next = bus.WB_EN & ~bus.REG_LIST[bus.BASE_REG];
          state_next      = (bus.REG_LIST != 16'd0) ? READ : FINISH;
        end
      end

      READ: begin
        mem_re     = 1'b1;
        mem_addr   = addr_reg;
        state_next = WRITE;
      end

      WRITE: begin
        if (target == 4'd15) begin
          pc_load = 1'b1;
          pc_data = bus.MEM_RDATA;
        end else begin
          we3 = 1'b1;
          a3  = target;
          wd3 = bus.MEM_RDATA;
        end
        list_next = list_remaining;
        addr_next = addr_reg + 32'd4;
        if (list_remaining != 16'd0) begin
          state_next = READ;
        end else if (wb_pending_reg) begin
          state_next = WBASE;
        end else begin
          state_next = FINISH;
        end
      end

      WBASE: begin
        if (base_idx_reg == 4'd15) begin
          pc_load = 1'b1;
          pc_data = final_base_reg;
        end else begin
          we3 = 1'b1;
          a3  = base_idx_reg;
          wd3 = final_base_reg;
        end
        state_next = FINISH;
      end

      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.MEM_RE   = mem_re;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.WE3      = we3;
  assign bus.A3       = a3;
  assign bus.WD3      = wd3;
  assign bus.PC_LOAD  = pc_load;
  assign bus.PC_DATA  = pc_data;
  assign bus.DONE     = done;
  assign bus.BUSY     = (state_reg != IDLE);

endmodule

// File: tb/tb_ldm_sequencer.sv
// Scoreboard bench for ldm_sequencer: each launch queues the expected reads, writes,
// PC loads and DONE with their cycle offsets; a negedge monitor pops and compares them.
module tb_ldm_sequencer;

  typedef struct {
    int          kind;   // 0 read, 1 reg write, 2 pc load, 3 done
    logic [31:0] a;
    logic [31:0] d;
    int          off;
  } ev_t;

  logic CLK;
  logic RESET_N;
  ldm_sequencer_if bus();

  ldm_sequencer dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  ev_t         sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic [31:0] rd_addr = 32'd0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0304) return 32'h0000_0040;
    return (a ^ 32'hC0DE_0000) + 32'h11;
  endfunction

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rd_addr <= bus.MEM_ADDR;
  end
  assign bus.MEM_RDATA = mem_fn(rd_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    int          ns;
    int          k;
    logic [31:0] oa;
    logic [31:0] od;
    logic [31:0] g;
    ev_t         e;
    g = (bus.MEM_RE ? 32'h0 : bus.MEM_ADDR)
      | (bus.WE3 ? 32'h0 : (bus.WD3 | {28'h0, bus.A3}))
      | (bus.PC_LOAD ? 32'h0 : bus.PC_DATA);
    chk("gated_zero", g, 32'h0);
    ns = bus.MEM_RE + bus.WE3 + bus.PC_LOAD + bus.DONE;
    if (ns != 0) begin
      chk("exclusive", ns, 1);
      k  = bus.MEM_RE ? 0 : bus.WE3 ? 1 : bus.PC_LOAD ? 2 : 3;
      oa = bus.MEM_RE ? bus.MEM_ADDR : bus.WE3 ? {28'h0, bus.A3} : 32'h0;
      od = bus.WE3 ? bus.WD3 : bus.PC_LOAD ? bus.PC_DATA : 32'h0;
      $display("txn cyc=%0d off=%0d kind=%0d a=%h d=%h", cyc, cyc - start_cyc, k, oa, od);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", ns, 0);
      end else begin
        e = sb.pop_front();
        chk("kind", k, e.kind);
        chk("addr_idx", oa, e.a);
        chk("data", od, e.d);
        chk("cycle", cyc - start_cyc, e.off);
        if (k == 3) chk("busy_at_done", {31'h0, bus.BUSY}, 32'h1);
      end
    end
  end

  // Caller is just after a negedge; returns one negedge later (offset 1)
  task automatic launch(input logic [15:0] l, input logic [31:0] b, input logic inc,
                        input logic wb, input logic [3:0] r);
    int          n;
    int          off;
    logic [31:0] a;
    logic [31:0] span;
    logic [31:0] fin;
    n = 0;
    for (int i = 0; i < 16; i++) n += l[i];
    span = 32'(n) * 32'd4;
    a    = inc ? b : b - span;
    off  = 1;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) begin
        sb.push_back(ev_t'{0, a, 32'h0, off});
        if (i == 15) sb.push_back(ev_t'{2, 32'h0, mem_fn(a), off + 1});
        else         sb.push_back(ev_t'{1, 32'(i), mem_fn(a), off + 1});
        a   = a + 32'd4;
        off = off + 2;
      end
    end
    if (n != 0 && wb && !l[r]) begin
      fin = inc ? b + span : b - span;
      if (r == 4'd15) sb.push_back(ev_t'{2, 32'h0, fin, off});
      else            sb.push_back(ev_t'{1, {28'h0, r}, fin, off});
      off++;
    end
    sb.push_back(ev_t'{3, 32'h0, 32'h0, off});
    bus.REG_LIST = l;
    bus.BASE     = b;
    bus.INC      = inc;
    bus.WB_EN    = wb;
    bus.BASE_REG = r;
    bus.START    = 1'b1;
    start_cyc    = cyc;
    @(negedge CLK);
    bus.START    = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(negedge CLK);
      #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge CLK);
    chk("idle_busy", {31'h0, bus.BUSY}, 32'h0);
  endtask

  initial begin
    RESET_N      = 1'b0;
    bus.START    = 1'b0;
    bus.REG_LIST = 16'h0;
    bus.BASE     = 32'h0;
    bus.INC      = 1'b0;
    bus.WB_EN    = 1'b0;
    bus.BASE_REG = 4'h0;
    #1;
    chk("reset_strobes", {27'h0, bus.MEM_RE, bus.WE3, bus.PC_LOAD, bus.BUSY, bus.DONE}, 32'h0);
    chk("reset_data", bus.MEM_ADDR | bus.WD3 | bus.PC_DATA | {28'h0, bus.A3}, 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Ascending load, base in list; START re-asserted with junk while busy
    launch(16'h0016, 32'h0000_0100, 1'b1, 1'b1, 4'd4);
    bus.START    = 1'b1;
    bus.REG_LIST = 16'hFFFF;
    bus.BASE     = 32'hDEAD_0000;
    bus.INC      = 1'b0;
    bus.BASE_REG = 4'd1;
    repeat (2) @(negedge CLK);
    bus.START    = 1'b0;
    drain();

    launch(16'h0003, 32'h0000_0200, 1'b0, 1'b1, 4'd13);
    drain();
    launch(16'h8001, 32'h0000_0300, 1'b1, 1'b0, 4'd0);
    drain();
    launch(16'h0000, 32'h0000_0040, 1'b1, 1'b1, 4'd3);
    drain();
    launch(16'h0003, 32'h0000_0080, 1'b1, 1'b1, 4'd15);
    drain();
    launch(16'hFFFF, 32'h0000_1000, 1'b0, 1'b1, 4'd5);
    drain();

    // Reset during the second WRITE: everything drops at once, nothing further
    launch(16'h0007, 32'h0000_0500, 1'b1, 1'b1, 4'd9);
    repeat (3) @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midrst_strobes", {27'h0, bus.MEM_RE, bus.WE3, bus.PC_LOAD, bus.BUSY, bus.DONE}, 32'h0);
    chk("midrst_data", bus.MEM_ADDR | bus.WD3 | bus.PC_DATA | {28'h0, bus.A3}, 32'h0);
    sb.delete();
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // Accepted on the first edge after release; address wraps past 2^32
    launch(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b0, 4'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
